// File: rtl/p_mc_control.sv
// rtl/p_mc_control.sv - multi-cycle MIPS control sequencer with memory-ready timeout
module p_mc_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             P_clk,
  input  logic             P_reset,
  input  logic [5:0]       P_Op,
  input  logic             P_MemReady,
  output logic             P_PCWrite,
  output logic             P_Branch,
  output logic [1:0]       P_PCSrc,
  output logic             P_IorD,
  output logic             P_MemRead,
  output logic             P_MemWrite,
  output logic             P_IRWrite,
  output logic             P_RegDst,
  output logic             P_MemtoReg,
  output logic             P_RegWrite,
  output logic             P_ALUSrcA,
  output logic [1:0]       P_ALUSrcB,
  output logic [1:0]       P_ALUOp,
  output logic             P_ExtSel,
  output logic [3:0]       P_State,
  output logic             P_Illegal,
  output logic             P_Fault,
  output logic [CNT_W-1:0] P_Retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // The counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               in_wait_state;
  logic               timeout_hit;
  logic               retiring;

  // State, wait counter and retired counter registers; reset wins over everything.
  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state selection, including the not-ready timeout trap.
  always_comb begin
    state_d       = state_q;
    in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout_hit   = (TIMEOUT > 0) && !P_MemReady && (wait_q == WAIT_W'(TIMEOUT - 1));
    case (state_q)
      S_FETCH:  state_d = P_MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (P_Op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_RTEXE;
          OP_BEQ:          state_d = S_BEQ;
          OP_ADDI, OP_ORI: state_d = S_IEXE;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (P_Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = P_MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = P_MemReady ? S_FETCH : S_MEMWR;
      S_RTEXE:  state_d = S_RTWB;
      S_IEXE:   state_d = S_IWB;
      S_MEMWB, S_RTWB, S_BEQ, S_IWB, S_JUMP: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    if (in_wait_state && timeout_hit) begin
      state_d = S_FAULT;
    end
  end

  // Wait counter restarts on entry to a memory-wait state and counts not-ready cycles;
  // the retired counter bumps when a completed instruction returns to FETCH.
  always_comb begin
    wait_d    = wait_q;
    retired_d = retired_q;
    retiring  = 1'b0;
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR))) begin
      wait_d = '0;
    end else if (in_wait_state && !P_MemReady) begin
      wait_d = wait_q + 1'b1;
    end
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_IWB, S_JUMP: retiring = 1'b1;
        default:                                         retiring = 1'b0;
      endcase
    end
    if (retiring) begin
      retired_d = retired_q + 1'b1;
    end
  end

  // Moore datapath controls decoded from the current state; only FETCH looks at ready.
  always_comb begin
    P_PCWrite  = 1'b0;
    P_Branch   = 1'b0;
    P_PCSrc    = 2'b00;
    P_IorD     = 1'b0;
    P_MemRead  = 1'b0;
    P_MemWrite = 1'b0;
    P_IRWrite  = 1'b0;
    P_RegDst   = 1'b0;
    P_MemtoReg = 1'b0;
    P_RegWrite = 1'b0;
    P_ALUSrcA  = 1'b0;
    P_ALUSrcB  = 2'b00;
    P_ALUOp    = 2'b00;
    P_ExtSel   = 1'b0;
    P_Illegal  = 1'b0;
    P_Fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        P_MemRead = 1'b1;
        P_ALUSrcB = 2'b01;
        P_IRWrite = P_MemReady;
        P_PCWrite = P_MemReady;
      end
      S_DECODE: begin
        P_ALUSrcB = 2'b11;
        case (P_Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_J: P_Illegal = 1'b0;
          default:                                               P_Illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        P_ALUSrcA = 1'b1;
        P_ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        P_IorD    = 1'b1;
        P_MemRead = 1'b1;
      end
      S_MEMWB: begin
        P_MemtoReg = 1'b1;
        P_RegWrite = 1'b1;
      end
      S_MEMWR: begin
        P_IorD     = 1'b1;
        P_MemWrite = 1'b1;
      end
      S_RTEXE: begin
        P_ALUSrcA = 1'b1;
        P_ALUOp   = 2'b10;
      end
      S_RTWB: begin
        P_RegDst   = 1'b1;
        P_RegWrite = 1'b1;
      end
      S_BEQ: begin
        P_ALUSrcA = 1'b1;
        P_ALUOp   = 2'b01;
        P_PCSrc   = 2'b01;
        P_Branch  = 1'b1;
      end
      S_IEXE, S_IWB: begin
        P_ALUSrcA  = 1'b1;
        P_ALUSrcB  = 2'b10;
        P_ALUOp    = (P_Op == OP_ORI) ? 2'b11 : 2'b00;
        P_ExtSel   = (P_Op == OP_ORI);
        P_RegWrite = (state_q == S_IWB);
      end
      S_JUMP: begin
        P_PCSrc   = 2'b10;
        P_PCWrite = 1'b1;
      end
      S_FAULT: P_Fault = 1'b1;
      default: P_Fault = 1'b0;
    endcase
  end

  assign P_State   = state_q;
  assign P_Retired = retired_q;

endmodule

// File: tb/tb_p_mc_control.sv
// tb/tb_p_mc_control.sv - directed self-checking bench for p_mc_control
module tb_p_mc_control;

  logic        P_clk;
  logic        P_reset;
  logic [5:0]  P_Op;
  logic        P_MemReady;
  logic        P_PCWrite, P_Branch, P_IorD, P_MemRead, P_MemWrite, P_IRWrite;
  logic        P_RegDst, P_MemtoReg, P_RegWrite, P_ALUSrcA, P_ExtSel;
  logic        P_Illegal, P_Fault;
  logic [1:0]  P_PCSrc, P_ALUSrcB, P_ALUOp;
  logic [3:0]  P_State;
  logic [15:0] P_Retired;

  int checks = 0;
  int errors = 0;

  p_mc_control #(.TIMEOUT(4), .CNT_W(16)) dut (
    .P_clk      (P_clk),
    .P_reset    (P_reset),
    .P_Op       (P_Op),
    .P_MemReady (P_MemReady),
    .P_PCWrite  (P_PCWrite),
    .P_Branch   (P_Branch),
    .P_PCSrc    (P_PCSrc),
    .P_IorD     (P_IorD),
    .P_MemRead  (P_MemRead),
    .P_MemWrite (P_MemWrite),
    .P_IRWrite  (P_IRWrite),
    .P_RegDst   (P_RegDst),
    .P_MemtoReg (P_MemtoReg),
    .P_RegWrite (P_RegWrite),
    .P_ALUSrcA  (P_ALUSrcA),
    .P_ALUSrcB  (P_ALUSrcB),
    .P_ALUOp    (P_ALUOp),
    .P_ExtSel   (P_ExtSel),
    .P_State    (P_State),
    .P_Illegal  (P_Illegal),
    .P_Fault    (P_Fault),
    .P_Retired  (P_Retired)
  );

  initial P_clk = 1'b0;
  always #5 P_clk = ~P_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the falling edge.
  task automatic step();
    @(negedge P_clk);
    #1;
  endtask

  initial begin
    P_reset = 1'b1;
    P_Op = 6'd0;
    P_MemReady = 1'b0;
    step();
    step();
    chk("rst_state", P_State, 0);
    chk("rst_retired", P_Retired, 0);
    chk("rst_fault", P_Fault, 0);

    // R-type with ready tied high: 0,1,6,7,0
    P_reset = 1'b0;
    P_MemReady = 1'b1;
    P_Op = 6'd0;
    #1;
    chk("r_fetch_state", P_State, 0);
    chk("r_fetch_memread", P_MemRead, 1);
    chk("r_fetch_irwrite", P_IRWrite, 1);
    chk("r_fetch_pcwrite", P_PCWrite, 1);
    chk("r_fetch_alusrcb", P_ALUSrcB, 1);
    chk("r_fetch_regwrite", P_RegWrite, 0);
    step();
    chk("r_decode_state", P_State, 1);
    chk("r_decode_alusrcb", P_ALUSrcB, 3);
    chk("r_decode_regwrite", P_RegWrite, 0);
    step();
    chk("r_exe_state", P_State, 6);
    chk("r_exe_aluop", P_ALUOp, 2);
    chk("r_exe_regwrite", P_RegWrite, 0);
    chk("r_exe_regdst", P_RegDst, 0);
    step();
    chk("r_wb_state", P_State, 7);
    chk("r_wb_regwrite", P_RegWrite, 1);
    chk("r_wb_regdst", P_RegDst, 1);
    step();
    chk("r_done_state", P_State, 0);
    chk("r_done_retired", P_Retired, 1);

    // LW, ready low for three MEMRD cycles; ready on the limit cycle must not fault
    P_Op = 6'd35;
    step();
    chk("lw_decode", P_State, 1);
    step();
    chk("lw_memadr", P_State, 2);
    chk("lw_memadr_alusrca", P_ALUSrcA, 1);
    chk("lw_memadr_alusrcb", P_ALUSrcB, 2);
    P_MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_memrd_state", P_State, 3);
      chk("lw_memrd_memread", P_MemRead, 1);
      chk("lw_memrd_iord", P_IorD, 1);
    end
    step();
    P_MemReady = 1'b1;
    #1;
    chk("lw_memrd4_state", P_State, 3);
    chk("lw_memrd4_memread", P_MemRead, 1);
    step();
    chk("lw_memwb_state", P_State, 4);
    chk("lw_memwb_memtoreg", P_MemtoReg, 1);
    chk("lw_memwb_regwrite", P_RegWrite, 1);
    chk("lw_memwb_regdst", P_RegDst, 0);
    step();
    chk("lw_done_state", P_State, 0);
    chk("lw_done_retired", P_Retired, 2);
    chk("lw_done_fault", P_Fault, 0);

    // ORI
    P_Op = 6'd13;
    step();
    step();
    chk("ori_iexe_state", P_State, 9);
    chk("ori_iexe_aluop", P_ALUOp, 3);
    chk("ori_iexe_extsel", P_ExtSel, 1);
    chk("ori_iexe_alusrcb", P_ALUSrcB, 2);
    chk("ori_iexe_regwrite", P_RegWrite, 0);
    step();
    chk("ori_iwb_state", P_State, 10);
    chk("ori_iwb_aluop", P_ALUOp, 3);
    chk("ori_iwb_extsel", P_ExtSel, 1);
    chk("ori_iwb_regwrite", P_RegWrite, 1);
    chk("ori_iwb_regdst", P_RegDst, 0);
    chk("ori_iwb_memtoreg", P_MemtoReg, 0);
    step();
    chk("ori_done_retired", P_Retired, 3);

    // ADDI
    P_Op = 6'd8;
    step();
    step();
    chk("addi_iexe_state", P_State, 9);
    chk("addi_iexe_aluop", P_ALUOp, 0);
    chk("addi_iexe_extsel", P_ExtSel, 0);
    step();
    chk("addi_iwb_regwrite", P_RegWrite, 1);
    chk("addi_iwb_extsel", P_ExtSel, 0);
    step();
    chk("addi_done_retired", P_Retired, 4);

    // Illegal opcode
    P_Op = 6'd63;
    chk("ill_fetch_illegal", P_Illegal, 0);
    step();
    chk("ill_decode_state", P_State, 1);
    chk("ill_decode_illegal", P_Illegal, 1);
    step();
    chk("ill_back_state", P_State, 0);
    chk("ill_back_illegal", P_Illegal, 0);
    chk("ill_retired", P_Retired, 4);

    // SW, reset while waiting in MEMWR
    P_Op = 6'd43;
    step();
    step();
    chk("sw_memadr", P_State, 2);
    P_MemReady = 1'b0;
    step();
    chk("sw_memwr_state", P_State, 5);
    chk("sw_memwr_memwrite", P_MemWrite, 1);
    chk("sw_memwr_iord", P_IorD, 1);
    P_reset = 1'b1;
    step();
    chk("sw_rst_state", P_State, 0);
    chk("sw_rst_retired", P_Retired, 0);
    chk("sw_rst_memwrite", P_MemWrite, 0);
    chk("sw_rst_fault", P_Fault, 0);

    // Timeout in FETCH: four not-ready cycles trap to FAULT
    P_reset = 1'b0;
    P_MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("to_fetch_state", P_State, 0);
      chk("to_fetch_irwrite", P_IRWrite, 0);
    end
    step();
    chk("to_fault_state", P_State, 15);
    chk("to_fault_flag", P_Fault, 1);
    chk("to_fault_memread", P_MemRead, 0);
    P_MemReady = 1'b1;
    step();
    chk("to_fault_sticky", P_State, 15);
    chk("to_fault_sticky_flag", P_Fault, 1);
    P_reset = 1'b1;
    step();
    chk("fault_rst_state", P_State, 0);
    chk("fault_rst_fault", P_Fault, 0);
    chk("fault_rst_retired", P_Retired, 0);

    // Ready on the fourth FETCH cycle wins over the timeout
    P_reset = 1'b0;
    P_MemReady = 1'b0;
    P_Op = 6'd2;
    step();
    step();
    step();
    P_MemReady = 1'b1;
    #1;
    chk("lim_fetch_state", P_State, 0);
    chk("lim_fetch_irwrite", P_IRWrite, 1);
    step();
    chk("lim_decode_state", P_State, 1);
    chk("lim_decode_fault", P_Fault, 0);

    // Jump
    step();
    chk("j_state", P_State, 11);
    chk("j_pcwrite", P_PCWrite, 1);
    chk("j_pcsrc", P_PCSrc, 2);
    step();
    chk("j_done_state", P_State, 0);
    chk("j_done_retired", P_Retired, 1);

    // BEQ
    P_Op = 6'd4;
    step();
    step();
    chk("beq_state", P_State, 8);
    chk("beq_branch", P_Branch, 1);
    chk("beq_aluop", P_ALUOp, 1);
    chk("beq_pcsrc", P_PCSrc, 1);
    chk("beq_pcwrite", P_PCWrite, 0);
    step();
    chk("beq_done_state", P_State, 0);
    chk("beq_done_retired", P_Retired, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
